field_mask_sequencer: RTL and testbench

Per-packet controller that drives byte-mask generation for a field-extraction datapath. It accepts one field descriptor per packet (byte offset and byte length), watches the AXI-Stream beat handshakes of that packet, and emits one registered byte mask per beat covering exactly the field bytes in that beat. It sits beside the packet pipeline in the reference switch and feeds the extract/compare stages that consume `beat_mask`.

---
 rtl/field_mask_sequencer.sv | 172 +++++++++++++++++
 tb/tb_field_mask_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/field_mask_sequencer.sv
// Per-packet byte-mask sequencer: tracks beats of a configured packet
// and emits a registered mask of the field bytes present in each beat.
module field_mask_sequencer #(
    parameter int MASK_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 16
) (
    input  logic                    axis_aclk,
    input  logic                    axis_resetn,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [OFFSET_WIDTH-1:0] cfg_offset,
    input  logic [OFFSET_WIDTH-1:0] cfg_length,
    input  logic                    s_tvalid,
    input  logic                    s_tready,
    input  logic                    s_tlast,
    output logic                    mask_valid,
    output logic [MASK_WIDTH-1:0]   beat_mask,
    output logic                    field_first,
    output logic                    field_last,
    output logic                    done,
    output logic                    error
);

    localparam int LW = $clog2(MASK_WIDTH);
    localparam int CW = OFFSET_WIDTH - LW + 2;
    localparam int EW = OFFSET_WIDTH + 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0]              state_q;
    logic [0:0]              state_d;
    logic                    in_packet_q;
    logic                    in_packet_d;
    logic [OFFSET_WIDTH-1:0] off_q;
    logic [OFFSET_WIDTH-1:0] len_q;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           cnt_d;
    logic                    last_seen_q;
    logic                    last_seen_d;
    logic                    ready_d;

    logic beat;
    logic accept;
    logic live;
    logic emit;

    assign beat   = s_tvalid && s_tready;
    assign accept = cfg_valid && cfg_ready;
    assign live   = accept || (state_q == S_ACTIVE);
    assign emit   = beat && live;

    // A beat in the acceptance cycle is decoded straight from cfg_* as beat 0.
    logic [OFFSET_WIDTH-1:0] dec_off;
    logic [OFFSET_WIDTH-1:0] dec_len;
    logic [CW-1:0]           dec_cnt;
    logic                    dec_seen;

    assign dec_off  = accept ? cfg_offset : off_q;
    assign dec_len  = accept ? cfg_length : len_q;
    assign dec_cnt  = accept ? '0 : cnt_q;
    assign dec_seen = accept ? 1'b0 : last_seen_q;

    logic [EW-1:0]         end_byte;
    logic [CW-1:0]         start_beat;
    logic [CW-1:0]         end_beat;
    logic [LW-1:0]         start_idx;
    logic [LW-1:0]         end_idx;
    logic                  len_nz;
    logic                  is_start;
    logic                  is_end;
    logic                  in_range;
    logic [LW-1:0]         lo;
    logic [LW-1:0]         hi;
    logic [MASK_WIDTH-1:0] lo_mask;
    logic [MASK_WIDTH-1:0] hi_mask;
    logic [MASK_WIDTH-1:0] mask_d;
    logic                  first_d;
    logic                  last_d;

    assign end_byte   = {1'b0, dec_off} + {1'b0, dec_len} - EW'(1);
    assign start_beat = CW'(dec_off >> LW);
    assign end_beat   = CW'(end_byte >> LW);
    assign start_idx  = dec_off[LW-1:0];
    assign end_idx    = end_byte[LW-1:0];
    assign len_nz     = |dec_len;
    assign is_start   = (dec_cnt == start_beat);
    assign is_end     = (dec_cnt == end_beat);
    assign in_range   = len_nz && (dec_cnt >= start_beat) && (dec_cnt <= end_beat);

    // (MASK_WIDTH-1) - hi equals ~hi at LW bits.
    assign lo      = is_start ? start_idx : '0;
    assign hi      = is_end ? end_idx : '1;
    assign lo_mask = {MASK_WIDTH{1'b1}} << lo;
    assign hi_mask = {MASK_WIDTH{1'b1}} >> (~hi);
    assign mask_d  = in_range ? (lo_mask & hi_mask) : '0;
    assign first_d = len_nz && is_start;
    assign last_d  = len_nz && is_end;

    always_comb begin
        state_d     = state_q;
        in_packet_d = in_packet_q;
        cnt_d       = cnt_q;
        last_seen_d = last_seen_q;
        if (beat) begin
            in_packet_d = !s_tlast;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d       = beat ? CW'(1) : '0;
                    last_seen_d = beat && last_d;
                    state_d     = (beat && s_tlast) ? S_IDLE : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (beat) begin
                    cnt_d       = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
                    last_seen_d = last_seen_q || last_d;
                    if (s_tlast) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE) && !in_packet_d;
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q     <= S_IDLE;
            in_packet_q <= 1'b0;
            cnt_q       <= '0;
            last_seen_q <= 1'b0;
            off_q       <= '0;
            len_q       <= '0;
            cfg_ready   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_packet_q <= in_packet_d;
            cnt_q       <= cnt_d;
            last_seen_q <= last_seen_d;
            cfg_ready   <= ready_d;
            if (accept) begin
                off_q <= cfg_offset;
                len_q <= cfg_length;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            mask_valid  <= 1'b0;
            beat_mask   <= '0;
            field_first <= 1'b0;
            field_last  <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            mask_valid <= emit;
            done       <= emit && s_tlast;
            error      <= emit && s_tlast && len_nz && !(dec_seen || last_d);
            if (emit) begin
                beat_mask   <= mask_d;
                field_first <= first_d;
                field_last  <= last_d;
            end
        end
    end

endmodule

// File: tb/tb_field_mask_sequencer.sv
// Directed bench for field_mask_sequencer with hand-computed masks.
module tb_field_mask_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_offset;
    logic [15:0] cfg_length;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        mask_valid;
    logic [31:0] beat_mask;
    logic        field_first;
    logic        field_last;
    logic        done;
    logic        error;

    int n_tests;
    int n_fail;

    field_mask_sequencer #(
        .MASK_WIDTH  (32),
        .OFFSET_WIDTH(16)
    ) dut (
        .axis_aclk  (clk),
        .axis_resetn(rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_offset (cfg_offset),
        .cfg_length (cfg_length),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .mask_valid (mask_valid),
        .beat_mask  (beat_mask),
        .field_first(field_first),
        .field_last (field_last),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic cyc(input logic cv, input logic [15:0] off,
                       input logic [15:0] len, input logic v,
                       input logic r, input logic l);
        @(negedge clk);
        cfg_valid  = cv;
        cfg_offset = off;
        cfg_length = len;
        s_tvalid   = v;
        s_tready   = r;
        s_tlast    = l;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic mv,
                              input logic [31:0] m, input logic ff,
                              input logic fl, input logic dn,
                              input logic er);
        check({tag, ".mv"}, 32'(mask_valid), 32'(mv));
        check({tag, ".done"}, 32'(done), 32'(dn));
        if (mv) begin
            check({tag, ".mask"}, beat_mask, m);
            check({tag, ".first"}, 32'(field_first), 32'(ff));
            check({tag, ".last"}, 32'(field_last), 32'(fl));
        end
        if (dn) check({tag, ".err"}, 32'(error), 32'(er));
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_offset = '0;
        cfg_length = '0;
        s_tvalid   = 1'b0;
        s_tready   = 1'b0;
        s_tlast    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", 32'(cfg_ready), 0);
        check("rst.mv", 32'(mask_valid), 0);
        check("rst.mask", beat_mask, 0);
        check("rst.done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel.ready", 32'(cfg_ready), 1);

        // Field spanning two beats
        cyc(1, 16'd14, 16'd20, 0, 0, 0);
        check("t1.ready", 32'(cfg_ready), 0);
        expect_out("t1.acc", 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        expect_out("t1.b0", 1, 32'hFFFFC000, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        expect_out("t1.b1", 1, 32'h00000003, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 1);
        expect_out("t1.b2", 1, 32'h00000000, 0, 0, 1, 0);
        check("t1.ready2", 32'(cfg_ready), 1);

        // Field inside one beat with backpressure
        cyc(1, 16'd2, 16'd4, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        expect_out("t2.stall0", 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        expect_out("t2.b0", 1, 32'h0000003C, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        expect_out("t2.idle", 0, 0, 0, 0, 0, 0);
        check("t2.hold", beat_mask, 32'h0000003C);
        cyc(0, 0, 0, 1, 0, 1);
        expect_out("t2.stall1", 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1);
        expect_out("t2.b1", 1, 32'h0, 0, 0, 1, 0);

        // Truncated packet
        cyc(1, 16'd40, 16'd30, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        expect_out("t3.b0", 1, 32'h0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1);
        expect_out("t3.b1", 1, 32'hFFFFFF00, 1, 0, 1, 1);

        // Descriptor with first beat, then back-to-back packet
        cyc(1, 16'd64, 16'd4, 1, 1, 0);
        expect_out("t4.b0", 1, 32'h0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        expect_out("t4.b1", 1, 32'h0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1);
        expect_out("t4.b2", 1, 32'h0000000F, 1, 1, 1, 0);
        check("t4.ready", 32'(cfg_ready), 1);
        cyc(1, 16'd5, 16'd3, 1, 1, 0);
        expect_out("t4.p2b0", 1, 32'h000000E0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 1);
        expect_out("t4.p2b1", 1, 32'h0, 0, 0, 1, 0);

        // Length 0, then an unconfigured packet
        cyc(1, 16'd7, 16'd0, 1, 1, 0);
        expect_out("t5.b0", 1, 32'h0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1);
        expect_out("t5.b1", 1, 32'h0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        expect_out("t5.u0", 0, 0, 0, 0, 0, 0);
        check("t5.u0rdy", 32'(cfg_ready), 0);
        cyc(1, 16'd1, 16'd1, 1, 1, 0);
        expect_out("t5.u1", 0, 0, 0, 0, 0, 0);
        check("t5.u1rdy", 32'(cfg_ready), 0);
        cyc(0, 0, 0, 1, 1, 1);
        expect_out("t5.u2", 0, 0, 0, 0, 0, 0);
        check("t5.u2rdy", 32'(cfg_ready), 1);

        // Reset mid-packet
        cyc(1, 16'd0, 16'd100, 1, 1, 0);
        expect_out("t6.b0", 1, 32'hFFFFFFFF, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        expect_out("t6.b1", 1, 32'hFFFFFFFF, 0, 0, 0, 0);
        @(negedge clk);
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tready = 1'b0;
        s_tlast  = 1'b0;
        #1;
        check("t6.mv", 32'(mask_valid), 0);
        check("t6.mask", beat_mask, 0);
        check("t6.first", 32'(field_first), 0);
        check("t6.rdy", 32'(cfg_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6.rel", 32'(cfg_ready), 1);

        // Single-beat packet after reset
        cyc(1, 16'd3, 16'd2, 1, 1, 1);
        expect_out("t7.b0", 1, 32'h00000018, 1, 1, 1, 0);
        check("t7.rdy", 32'(cfg_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
